fifo_write_arbiter: RTL and testbench

- Shares the 8-bit write port of one `fifo` instance (ENTRIES deep) between NUM_REQ producers.
- Arbitration is round-robin with an optional burst lock. Each producer may hold the port for up to MAX_BURST consecutive writes.
- Also gates a single consumer's read request.
- Guarantees the FIFO is never written when full and never read when empty, so the FIFO's legality rules hold by construction.

---
 rtl/fifo_write_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter with burst lock sharing one FIFO write port among NUM_REQ producers,
// plus read-request gating for a single consumer. The FIFO is never written full or read empty.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    localparam int REQ_LOG2 = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*8-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic                  fifo_write_ctrl,
    output logic [7:0]            fifo_write_data,
    input  logic                  fifo_is_full,
    input  logic                  fifo_is_empty,
    input  logic                  cons_read_req,
    output logic                  fifo_read_ctrl,
    output logic [REQ_LOG2-1:0]   grant_owner,
    output logic                  locked
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]          state;
    logic [REQ_LOG2-1:0] last_owner;
    logic [CNT_W-1:0]    burst_cnt;

    logic                win_found;
    logic [REQ_LOG2-1:0] win_idx;
    logic                hold;
    logic                write_en;
    logic                new_grant;
    logic [REQ_LOG2-1:0] ack_idx;

    // First requester after last_owner, wrapping around to last_owner itself.
    always_comb begin : rr_search
        int scan;
        logic [REQ_LOG2-1:0] scan_idx;
        scan      = 0;
        scan_idx  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan     = (int'(last_owner) + k) % NUM_REQ;
            scan_idx = scan[REQ_LOG2-1:0];
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // A lock that is stalled by a full FIFO keeps the port without consuming burst budget.
    always_comb begin
        hold      = (state == ST_LOCKED) && req_valid[grant_owner] && (burst_cnt < BURST_LIMIT);
        write_en  = 1'b0;
        new_grant = 1'b0;
        ack_idx   = grant_owner;
        if (!rst && !fifo_is_full) begin
            if (hold) begin
                write_en = 1'b1;
            end else if (win_found) begin
                write_en  = 1'b1;
                new_grant = 1'b1;
                ack_idx   = win_idx;
            end
        end
    end

    always_comb begin
        req_ack          = '0;
        req_ack[ack_idx] = write_en;
    end

    assign fifo_write_ctrl = write_en;
    assign fifo_write_data = write_en ? req_data[{ack_idx, 3'b000} +: 8] : 8'h00;
    assign fifo_read_ctrl  = cons_read_req & ~fifo_is_empty & ~rst;
    assign locked          = (state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant_owner <= '0;
            last_owner  <= REQ_LOG2'(NUM_REQ - 1);
            burst_cnt   <= '0;
        end else if (new_grant) begin
            grant_owner <= ack_idx;
            last_owner  <= ack_idx;
            burst_cnt   <= CNT_W'(1);
            state       <= (MAX_BURST > 1) ? ST_LOCKED : ST_IDLE;
        end else if (hold) begin
            if (write_en) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end else begin
            state <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: three instances (MAX_BURST 4, 2, 1) share directed stimulus,
// each checked every cycle against a queue-free behavioural model plus literal expectations.
module tb_fifo_write_arbiter;

    localparam int NREQ = 4;
    localparam int MB_A [3] = '{4, 2, 1};

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        full;
    logic        empty;
    logic        cons;

    logic [3:0]  ack_o   [3];
    logic        wctrl_o [3];
    logic [7:0]  wdata_o [3];
    logic        rd_o    [3];
    logic [1:0]  gown_o  [3];
    logic        lck_o   [3];

    int n_cmp;
    int n_bad;

    // Model state per instance: owner -1 means no lock held.
    int  m_owner [3];
    int  m_used  [3];
    int  m_last  [3];
    int  m_gown  [3];
    int  m_wait  [3][4];
    bit  m_ok;

    int  seq2 [$];
    int  seq1 [$];
    int  exp2 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int  exp1 [5]  = '{0, 1, 2, 3, 0};

    logic [4:0] pat [12] = '{5'b0_1111, 5'b1_1111, 5'b0_1010, 5'b0_1010, 5'b1_0110, 5'b0_0110,
                             5'b0_0001, 5'b0_1001, 5'b1_1001, 5'b0_1001, 5'b0_0000, 5'b0_1100};

    fifo_write_arbiter #(.NUM_REQ(4), .MAX_BURST(4)) u_mb4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ack(ack_o[0]), .fifo_write_ctrl(wctrl_o[0]), .fifo_write_data(wdata_o[0]),
        .fifo_is_full(full), .fifo_is_empty(empty), .cons_read_req(cons),
        .fifo_read_ctrl(rd_o[0]), .grant_owner(gown_o[0]), .locked(lck_o[0])
    );

    fifo_write_arbiter #(.NUM_REQ(4), .MAX_BURST(2)) u_mb2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ack(ack_o[1]), .fifo_write_ctrl(wctrl_o[1]), .fifo_write_data(wdata_o[1]),
        .fifo_is_full(full), .fifo_is_empty(empty), .cons_read_req(cons),
        .fifo_read_ctrl(rd_o[1]), .grant_owner(gown_o[1]), .locked(lck_o[1])
    );

    fifo_write_arbiter #(.NUM_REQ(4), .MAX_BURST(1)) u_mb1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ack(ack_o[2]), .fifo_write_ctrl(wctrl_o[2]), .fifo_write_data(wdata_o[2]),
        .fifo_is_full(full), .fifo_is_empty(empty), .cons_read_req(cons),
        .fifo_read_ctrl(rd_o[2]), .grant_owner(gown_o[2]), .locked(lck_o[2])
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit holding(input int k);
        if (rst || m_owner[k] < 0) return 1'b0;
        return req_valid[m_owner[k][1:0]] && (m_used[k] < MB_A[k]);
    endfunction

    // Producer index written this cycle, or -1.
    function automatic int pick(input int k);
        int c;
        if (rst || full) return -1;
        if (holding(k)) return m_owner[k];
        for (int s = 1; s <= NREQ; s++) begin
            c = (m_last[k] + s) % NREQ;
            if (req_valid[c[1:0]]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int a;
        if (rst) begin
            m_ok <= 1'b1;
            for (int k = 0; k < 3; k++) begin
                m_owner[k] <= -1;
                m_used[k]  <= 0;
                m_last[k]  <= NREQ - 1;
                m_gown[k]  <= 0;
                for (int p = 0; p < 4; p++) m_wait[k][p] <= 0;
            end
        end else if (m_ok) begin
            for (int k = 0; k < 3; k++) begin
                a = pick(k);
                if (holding(k)) begin
                    if (a >= 0) m_used[k] <= m_used[k] + 1;
                end else if (a >= 0) begin
                    m_last[k]  <= a;
                    m_gown[k]  <= a;
                    m_used[k]  <= 1;
                    m_owner[k] <= (MB_A[k] > 1) ? a : -1;
                end else begin
                    m_owner[k] <= -1;
                end
                for (int p = 0; p < 4; p++) begin
                    if (!req_valid[p] || ack_o[k][p]) m_wait[k][p] <= 0;
                    else if (!full) m_wait[k][p] <= m_wait[k][p] + 1;
                end
            end
        end
    end

    // Scoreboard: every output of every instance against the model, mid-cycle.
    always @(negedge clk) begin
        int a;
        logic [3:0] e_ack;
        logic [7:0] e_dat;
        if (m_ok) begin
            for (int k = 0; k < 3; k++) begin
                a = pick(k);
                e_ack = '0;
                e_dat = 8'h00;
                if (a >= 0) begin
                    e_ack[a[1:0]] = 1'b1;
                    e_dat = req_data[a*8 +: 8];
                end
                check($sformatf("m%0d_ack", k), ack_o[k], e_ack);
                check($sformatf("m%0d_wctrl", k), wctrl_o[k], (a >= 0) ? 1 : 0);
                check($sformatf("m%0d_wdata", k), wdata_o[k], e_dat);
                check($sformatf("m%0d_rd", k), rd_o[k], (cons && !empty && !rst) ? 1 : 0);
                check($sformatf("m%0d_owner", k), gown_o[k], m_gown[k]);
                check($sformatf("m%0d_locked", k), lck_o[k], (m_owner[k] >= 0) ? 1 : 0);
                check($sformatf("m%0d_onehot", k), $onehot0(ack_o[k]) ? 1 : 0, 1);
                check($sformatf("m%0d_ack_valid", k), ack_o[k] & ~req_valid, 0);
                check($sformatf("m%0d_wr_full", k), wctrl_o[k] & full, 0);
                check($sformatf("m%0d_rd_empty", k), rd_o[k] & empty, 0);
                for (int p = 0; p < 4; p++)
                    if (req_valid[p])
                        check($sformatf("m%0d_starve%0d", k, p),
                              (m_wait[k][p] <= (NREQ - 1) * MB_A[k]) ? 1 : 0, 1);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_ok  = 1'b0;
        rst = 1'b1;
        req_valid = 4'b0000;
        req_data  = {8'h3C, 8'h5A, 8'h96, 8'hA5};
        full  = 1'b0;
        empty = 1'b1;
        cons  = 1'b0;
        do_reset();

        @(negedge clk);
        check("rst_owner", gown_o[0], 0);
        check("rst_locked", lck_o[0], 0);
        check("rst_ack", ack_o[0], 0);
        tick();

        // Single producer, zero-latency write then lock
        req_valid = 4'b0001;
        @(negedge clk);
        check("t1_ack", ack_o[0], 4'b0001);
        check("t1_data", wdata_o[0], 8'hA5);
        check("t1_wctrl", wctrl_o[0], 1);
        tick();
        check("t1_owner", gown_o[0], 0);
        check("t1_locked", lck_o[0], 1);
        req_valid = 4'b0000;
        do_reset();

        // All four requesting: burst 2 and pure round-robin sequences
        req_valid = 4'b1111;
        repeat (10) begin
            @(negedge clk);
            seq2.push_back(idx(ack_o[1]));
            seq1.push_back(idx(ack_o[2]));
            tick();
        end
        for (int i = 0; i < 10; i++) check($sformatf("t2_mb2_seq%0d", i), seq2[i], exp2[i]);
        for (int i = 0; i < 5; i++) check($sformatf("t2_mb1_seq%0d", i), seq1[i], exp1[i]);
        req_valid = 4'b0000;
        do_reset();

        // Full stall on owner 1 does not consume burst budget
        req_valid = 4'b0010;
        @(negedge clk);
        check("t3_first", ack_o[0], 4'b0010);
        tick();
        full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall_ack", ack_o[0], 0);
            tick();
            check("t3_stall_lock", lck_o[0], 1);
        end
        full = 1'b0;
        @(negedge clk);
        check("t3_resume", ack_o[0], 4'b0010);
        tick();
        req_valid = 4'b0011;
        @(negedge clk);
        check("t3_burst3", ack_o[0], 4'b0010);
        tick();
        @(negedge clk);
        check("t3_burst4", ack_o[0], 4'b0010);
        tick();
        @(negedge clk);
        check("t3_release", ack_o[0], 4'b0001);
        tick();
        req_valid = 4'b0000;
        do_reset();

        // Owner 2 drops mid-burst: same-cycle handover to 3
        req_valid = 4'b0100;
        @(negedge clk);
        check("t4_grant2", ack_o[0], 4'b0100);
        tick();
        req_valid = 4'b1101;
        @(negedge clk);
        check("t4_burst2", ack_o[0], 4'b0100);
        tick();
        req_valid = 4'b1001;
        @(negedge clk);
        check("t4_handover", ack_o[0], 4'b1000);
        check("t4_data", wdata_o[0], 8'h3C);
        tick();
        check("t4_owner", gown_o[0], 3);
        check("t4_locked", lck_o[0], 1);
        req_valid = 4'b0000;
        do_reset();

        // Read gating
        cons = 1'b1;
        req_valid = 4'b0001;
        @(negedge clk);
        check("t5_rd_empty", rd_o[0], 0);
        check("t5_wr", wctrl_o[0], 1);
        tick();
        empty = 1'b0;
        @(negedge clk);
        check("t5_rd", rd_o[0], 1);
        check("t5_rd_wr", wctrl_o[0], 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t5_rd_rst", rd_o[0], 0);
        check("t5_wr_rst", wctrl_o[0], 0);
        tick();
        rst = 1'b0;
        req_valid = 4'b0000;
        cons = 1'b0;
        empty = 1'b1;
        tick();

        // Reset while locked on owner 1
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1111;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_ack", ack_o[0], 0);
        check("t6_rst_wctrl", wctrl_o[0], 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_regrant", ack_o[0], 4'b0001);
        tick();
        req_valid = 4'b0000;
        tick();

        // Mixed valid/full table, model-checked only
        for (int i = 0; i < 12; i++) begin
            full      = pat[i][4];
            req_valid = pat[i][3:0];
            cons      = pat[i][0];
            empty     = pat[i][1];
            tick();
        end
        req_valid = 4'b0000;
        full = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
